// File: rtl/fifo_rr_pop_arbiter_if.sv
// rtl/fifo_rr_pop_arbiter_if.sv - FIFO-side and downstream-side signal bundle for the VC pop arbiter
interface fifo_rr_pop_arbiter_if #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
);
    logic [3:0]              fifo_empty;
    logic [3:0]              fifo_almost_empty;
    logic [4*DATA_WIDTH-1:0] fifo_data;
    logic                    pause;
    logic [3:0]              fifo_pop;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    valid_out;
    logic [1:0]              src_id;
    logic [CNT_WIDTH-1:0]    word_count;

    modport master (
        input  fifo_empty,
        input  fifo_almost_empty,
        input  fifo_data,
        input  pause,
        output fifo_pop,
        output data_out,
        output valid_out,
        output src_id,
        output word_count
    );

    modport slave (
        output fifo_empty,
        output fifo_almost_empty,
        output fifo_data,
        output pause,
        input  fifo_pop,
        input  data_out,
        input  valid_out,
        input  src_id,
        input  word_count
    );
endinterface

// File: rtl/fifo_rr_pop_arbiter.sv
// rtl/fifo_rr_pop_arbiter.sv - round-robin pop arbiter over four VC FIFOs with 2-stage read pipeline
// Defining ARB_STRICT_PRIO_EN replaces round-robin with fixed priority VC0 > VC1 > VC2 > VC3.
module fifo_rr_pop_arbiter #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input logic                   clk,
    input logic                   reset,
    fifo_rr_pop_arbiter_if.master bus
);
    logic [3:0]            w_eligible;
    logic [3:0]            w_pop;
    logic                  w_grant_vld;
    logic [1:0]            w_grant_id;
    logic [DATA_WIDTH-1:0] w_pend_word;

    logic [3:0]            r_popped_last;
    logic                  r_pend_valid;
    logic [1:0]            r_pend_id;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic [1:0]            r_src_id;
    logic [CNT_WIDTH-1:0]  r_word_count;

    // FIFO flags lag their own pop by a cycle, so a count-1 FIFO just popped looks non-empty.
    assign w_eligible = ~bus.fifo_empty & ~(bus.fifo_almost_empty & r_popped_last);

`ifdef ARB_STRICT_PRIO_EN
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = 2'(i);
            end
        end
    end
`else
    logic [1:0] r_rr_ptr;
    logic [7:0] w_elig_dbl;
    logic [3:0] w_rot;
    logic [1:0] w_offset;

    // Rotate eligibility so bit 0 is the pointer's VC; lowest set bit is the winner's offset.
    assign w_elig_dbl = {w_eligible, w_eligible};
    assign w_rot      = w_elig_dbl[r_rr_ptr +: 4];

    always_comb begin
        w_grant_vld = 1'b0;
        w_offset    = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_grant_vld = 1'b1;
                w_offset    = 2'(k);
            end
        end
    end

    assign w_grant_id = r_rr_ptr + w_offset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 2'd0;
        end else if (|w_pop) begin
            r_rr_ptr <= w_grant_id + 2'd1;
        end
    end
`endif

    always_comb begin
        w_pop = 4'b0000;
        if (!reset && !bus.pause && w_grant_vld) begin
            w_pop[w_grant_id] = 1'b1;
        end
    end

    always_comb begin
        w_pend_word = bus.fifo_data[0 +: DATA_WIDTH];
        case (r_pend_id)
            2'd0: w_pend_word = bus.fifo_data[0*DATA_WIDTH +: DATA_WIDTH];
            2'd1: w_pend_word = bus.fifo_data[1*DATA_WIDTH +: DATA_WIDTH];
            2'd2: w_pend_word = bus.fifo_data[2*DATA_WIDTH +: DATA_WIDTH];
            2'd3: w_pend_word = bus.fifo_data[3*DATA_WIDTH +: DATA_WIDTH];
            default: w_pend_word = bus.fifo_data[0 +: DATA_WIDTH];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_popped_last <= 4'b0000;
            r_pend_valid  <= 1'b0;
            r_pend_id     <= 2'd0;
            r_data_out    <= '0;
            r_valid_out   <= 1'b0;
            r_src_id      <= 2'd0;
            r_word_count  <= '0;
        end else begin
            r_popped_last <= w_pop;
            r_pend_valid  <= |w_pop;
            if (|w_pop) begin
                r_pend_id <= w_grant_id;
            end
            // The FIFO's registered read data is valid the cycle after its pop.
            r_valid_out <= r_pend_valid;
            if (r_pend_valid) begin
                r_data_out <= w_pend_word;
                r_src_id   <= r_pend_id;
            end
            if (r_valid_out && (r_word_count != {CNT_WIDTH{1'b1}})) begin
                r_word_count <= r_word_count + 1'b1;
            end
        end
    end

    assign bus.fifo_pop   = w_pop;
    assign bus.data_out   = r_data_out;
    assign bus.valid_out  = r_valid_out;
    assign bus.src_id     = r_src_id;
    assign bus.word_count = r_word_count;
endmodule

// File: tb/tb_fifo_rr_pop_arbiter.sv
// tb/tb_fifo_rr_pop_arbiter.sv - directed self-checking bench for fifo_rr_pop_arbiter
module tb_fifo_rr_pop_arbiter;
    localparam int DW = 12;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;

    fifo_rr_pop_arbiter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    fifo_rr_pop_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // FIFO models: registered read data, flags registered from the occupancy (one cycle stale).
    logic [DW-1:0] mem [4][8];
    int            wr_cnt [4];
    int            rd_cnt [4];
    int            flag_cnt [4];
    logic [DW-1:0] dq [4];
    int            underflows = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            flag_cnt[i] <= wr_cnt[i] - rd_cnt[i];
            if (reset) begin
                rd_cnt[i] <= 0;
            end else if (bus.fifo_pop[i]) begin
                if (wr_cnt[i] - rd_cnt[i] <= 0) underflows <= underflows + 1;
                dq[i]     <= mem[i][rd_cnt[i] % 8];
                rd_cnt[i] <= rd_cnt[i] + 1;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_flags
        assign bus.fifo_empty[g]          = (flag_cnt[g] == 0);
        assign bus.fifo_almost_empty[g]   = (flag_cnt[g] == 1);
        assign bus.fifo_data[g*DW +: DW]  = dq[g];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        bus.pause = 1'b0;
        for (int i = 0; i < 4; i++) wr_cnt[i] = 0;
    endtask

    task automatic load(input int vc, input int n, input int base);
        for (int k = 0; k < n; k++) mem[vc][k] = DW'(base + k);
        wr_cnt[vc] = n;
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    int exp_g [8];
    int exp_d [6];
    int occ [4];
    int g;
    int n_valid;

    initial begin
        bus.pause = 1'b0;
        for (int i = 0; i < 4; i++) wr_cnt[i] = 0;
`ifdef ARB_STRICT_PRIO_EN
        exp_g = '{0, 0, 1, 1, 2, 2, 3, 3};
        exp_d = '{0, 0, 0, 3, 3, 3};
`else
        exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_d = '{0, 3, 0, 3, 0, 3};
`endif

        // Reset sweep: all FIFOs non-empty while reset is held.
        do_reset();
        for (int v = 0; v < 4; v++) load(v, 1, 12'h010 * (v + 1));
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check("rst_pop", 32'(bus.fifo_pop), 32'h0);
            check("rst_valid", 32'(bus.valid_out), 32'h0);
            check("rst_count", 32'(bus.word_count), 32'h0);
            check("rst_src", 32'(bus.src_id), 32'h0);
        end
        reset = 1'b0;
        #1;
        check("rst_first_pop", 32'(bus.fifo_pop), 32'h1);

        // Single VC: FIFO2 holds three words.
        do_reset();
        load(2, 3, 12'h0A1);
        release_reset();
        for (int c = 0; c < 7; c++) begin
            if (c > 0) next_cycle();
            check("single_pop", 32'(bus.fifo_pop), (c < 3) ? 32'h4 : 32'h0);
            check("single_valid", 32'(bus.valid_out), (c >= 2 && c <= 4) ? 32'h1 : 32'h0);
            if (c >= 2 && c <= 4) begin
                check("single_data", 32'(bus.data_out), 32'(12'h0A1 + c - 2));
                check("single_src", 32'(bus.src_id), 32'h2);
            end
            check("single_count", 32'(bus.word_count), (c <= 2) ? 32'h0 : 32'((c - 2 > 3) ? 3 : c - 2));
        end

        // Grant order with all four FIFOs holding two words.
        do_reset();
        for (int v = 0; v < 4; v++) load(v, 2, 12'h100 * (v + 1));
        for (int v = 0; v < 4; v++) occ[v] = 0;
        release_reset();
        for (int c = 0; c < 11; c++) begin
            if (c > 0) next_cycle();
            check("rr_pop", 32'(bus.fifo_pop), (c < 8) ? 32'(1 << exp_g[c]) : 32'h0);
            if (c >= 2 && c <= 9) begin
                g = exp_g[c - 2];
                check("rr_valid", 32'(bus.valid_out), 32'h1);
                check("rr_src", 32'(bus.src_id), 32'(g));
                check("rr_data", 32'(bus.data_out), 32'(12'h100 * (g + 1) + occ[g]));
                occ[g]++;
            end else begin
                check("rr_valid_idle", 32'(bus.valid_out), 32'h0);
            end
        end
        check("rr_count", 32'(bus.word_count), 32'h8);

        // Pause mid-stream from FIFO0.
        do_reset();
        load(0, 6, 12'h300);
        release_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                @(negedge clk);
                bus.pause = (c >= 2 && c < 5);
                #1;
            end
            check("pause_pop", 32'(bus.fifo_pop), (c < 2 || c >= 5) ? 32'h1 : 32'h0);
            check("pause_valid", 32'(bus.valid_out), (c == 2 || c == 3 || c == 7) ? 32'h1 : 32'h0);
            if (c == 2 || c == 3) check("pause_data", 32'(bus.data_out), 32'(12'h300 + c - 2));
            if (c == 7) check("resume_data", 32'(bus.data_out), 32'h302);
        end

        // Underflow guard: FIFO1 at count 1 with stale flags after its pop.
        do_reset();
        load(1, 1, 12'h5C5);
        release_reset();
        for (int c = 0; c < 5; c++) begin
            if (c > 0) next_cycle();
            check("guard_pop", 32'(bus.fifo_pop), (c == 0) ? 32'h2 : 32'h0);
            check("guard_valid", 32'(bus.valid_out), (c == 2) ? 32'h1 : 32'h0);
            if (c == 2) check("guard_data", 32'(bus.data_out), 32'h5C5);
        end
        check("guard_underflow", 32'(underflows), 32'h0);

        // FIFO0 vs FIFO3 ordering (fixed priority drains VC0 first).
        do_reset();
        load(0, 3, 12'h700);
        load(3, 3, 12'h7F0);
        release_reset();
        for (int c = 0; c < 7; c++) begin
            if (c > 0) next_cycle();
            check("order_pop", 32'(bus.fifo_pop), (c < 6) ? 32'(1 << exp_d[c]) : 32'h0);
        end

        // Saturation of the 4-bit delivered-word counter.
        do_reset();
        for (int v = 0; v < 4; v++) load(v, 5, 12'h040 * v);
        release_reset();
        n_valid = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) next_cycle();
            if (bus.valid_out === 1'b1) n_valid++;
        end
        check("sat_delivered", 32'(n_valid), 32'd20);
        check("sat_count", 32'(bus.word_count), 32'd15);
        check("sat_underflow", 32'(underflows), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
